// File: rtl/debug_frame_tx_if.sv
// Bus between the debug frame source, the frame serializer and the UART transmitter.
// Also carries the serializer state as a debug output.
interface debug_frame_tx_if #(
    parameter int NB_FRAME = 32,
    parameter int NB_BYTE  = 8
);
    // Handshakes:
    // - i_frame_valid is a strobe with no backpressure. One frame is offered on
    //   each high cycle; frames that find the FIFO full are dropped.
    // - o_tx_start is a one-cycle request carrying o_tx_data, which stays stable
    //   until the matching one-cycle i_tx_done arrives.
    logic [NB_FRAME-1:0] i_frame;
    logic                i_frame_valid;
    logic [NB_BYTE-1:0]  o_tx_data;
    logic                o_tx_start;
    logic                i_tx_done;
    logic                o_fifo_full;
    logic                o_overflow;
    logic                o_busy;
    logic [1:0]          o_state;

    modport master (
        output i_frame, i_frame_valid, i_tx_done,
        input  o_tx_data, o_tx_start, o_fifo_full, o_overflow, o_busy, o_state
    );

    modport slave (
        input  i_frame, i_frame_valid, i_tx_done,
        output o_tx_data, o_tx_start, o_fifo_full, o_overflow, o_busy, o_state
    );
endinterface

// File: rtl/debug_frame_tx.sv
// Buffers debug frames in a small FIFO and sends each one to a UART as bytes,
// most significant byte first.
module debug_frame_tx #(
    parameter int NB_FRAME   = 32,
    parameter int NB_BYTE    = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    debug_frame_tx_if.slave  bus
);
    localparam int DEPTH     = 2 ** LOG2_DEPTH;
    localparam int NUM_BYTES = NB_FRAME / NB_BYTE;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_W     = LOG2_DEPTH + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NB_FRAME-1:0]   mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic [NB_FRAME-1:0]   shift_q;
    logic [IDX_W-1:0]      idx_q;

    logic fifo_full, fifo_empty;
    logic push, pop, drop;
    logic last_byte_done;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // The only pop happens in LOAD. The FSM enters LOAD only when the FIFO is
    // non-empty, so a pop never underflows. A pop in the same cycle frees a
    // slot for a push.
    assign pop  = (state_q == ST_LOAD);
    assign push = bus.i_frame_valid & (~fifo_full | pop);
    assign drop = bus.i_frame_valid & fifo_full & ~pop;

    assign last_byte_done = (state_q == ST_WAIT) & bus.i_tx_done & (idx_q == LAST_IDX);

    always_ff @(posedge i_clock) begin
        if (!i_reset && push) begin
            mem[wr_ptr_q] <= bus.i_frame;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    state_d = last_byte_done ? ST_IDLE : ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The byte on o_tx_data is always the top byte of the shift register.
    // It therefore stays stable through WAIT and changes only when the next
    // byte is shifted in.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (state_q == ST_LOAD) begin
            shift_q <= mem[rd_ptr_q];
            idx_q   <= '0;
        end else if ((state_q == ST_WAIT) && bus.i_tx_done && !last_byte_done) begin
            shift_q <= shift_q << NB_BYTE;
            idx_q   <= idx_q + 1'b1;
        end
    end

    assign bus.o_tx_data   = shift_q[NB_FRAME-1 -: NB_BYTE];
    assign bus.o_tx_start  = (state_q == ST_SEND);
    assign bus.o_fifo_full = fifo_full;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_busy      = ~fifo_empty | (state_q != ST_IDLE);
    assign bus.o_state     = state_q;

endmodule
